// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and default widths for the RAM arbiter.
package ram_arb_pkg;
    localparam int DATA_W   = 16;
    localparam int MASK_W   = 4;
    localparam int ADDR_W   = 32;
    localparam int LOCK_MAX = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_e;
endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or above ptr_i wins, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               valid_o,
    output logic [IW-1:0]      idx_o
);
    int k;

    // Scan from the farthest offset down so the nearest request is assigned last.
    always_comb begin
        valid_o = 1'b0;
        idx_o = '0;
        k = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr_i) + i) % NUM_REQ;
            if (req_i[k]) begin
                valid_o = 1'b1;
                idx_o = IW'(k);
            end
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one nibble-masked synchronous RAM between NUM_REQ requesters.
// Optional RAM_ARB_LOCK_EN adds lock_i for bounded atomic re-grant bursts.
module ram_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ram_arb_pkg::ADDR_W,
    parameter int DATA_W  = ram_arb_pkg::DATA_W,
    parameter int MASK_W  = ram_arb_pkg::MASK_W
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_i,
`ifdef RAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         lock_i,
`endif
    input  logic [NUM_REQ-1:0]         wr_en_i,
    input  logic [NUM_REQ*MASK_W-1:0]  wr_mask_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       busy_o,
    output logic                       ram_sel_o,
    output logic                       ram_wr_en_o,
    output logic [MASK_W-1:0]          ram_wr_mask_o,
    output logic [ADDR_W-1:0]          ram_address_o,
    output logic [DATA_W-1:0]          ram_data_o,
    input  logic [DATA_W-1:0]          ram_data_i
);
    import ram_arb_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d, g_q, g_d, nxt, pick_ptr, pick_idx;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [NUM_REQ-1:0] g_bit, pick_req;
    logic               pick_valid, regrant, issue;

    assign g_bit = NUM_REQ'(1) << g_q;
    assign nxt = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
    // In ACK the current winner is masked and the scan starts just past it.
    assign pick_req = (state_q == ACK) ? (req_i & ~g_bit) : req_i;
    assign pick_ptr = (state_q == ACK) ? nxt : ptr_q;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req_i   (pick_req),
        .ptr_i   (pick_ptr),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef RAM_ARB_LOCK_EN
    logic [4:0] cnt_q, cnt_d;

    assign regrant = (state_q == ACK) & lock_i[g_q] & req_i[g_q] & (cnt_q < 5'(LOCK_MAX));

    // Counts consecutive grants of the current burst; any fresh grant restarts at 1.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == ISSUE && state_q != ISSUE)
            cnt_d = regrant ? cnt_q + 5'd1 : 5'd1;
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    assign regrant = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        g_d = g_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    g_d = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = ACK;
            ACK: begin
                rdata_d = ram_data_i;
                if (regrant) begin
                    state_d = ISSUE;
                end else begin
                    ptr_d = nxt;
                    state_d = pick_valid ? ISSUE : IDLE;
                    g_d = pick_valid ? pick_idx : g_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q <= '0;
            g_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            g_q <= g_d;
            rdata_q <= rdata_d;
        end
    end

    assign issue = (state_q == ISSUE);
    assign ram_sel_o = issue;
    assign ram_wr_en_o = issue & wr_en_i[g_q];
    assign ram_wr_mask_o = issue ? wr_mask_i[g_q*MASK_W +: MASK_W] : '0;
    assign ram_address_o = issue ? addr_i[g_q*ADDR_W +: ADDR_W] : '0;
    assign ram_data_o = issue ? wdata_i[g_q*DATA_W +: DATA_W] : '0;
    assign ack_o = (state_q == ACK) ? g_bit : '0;
    assign rdata_o = (state_q == ACK) ? ram_data_i : rdata_q;
    assign busy_o = (state_q != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a behavioural nibble-masked RAM.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [2:0]  req_i = '0;
`ifdef RAM_ARB_LOCK_EN
    logic [2:0]  lock_i = '0;
    logic [2:0]  seq [17];
`endif
    logic [2:0]  wr_en_i = '0;
    logic [11:0] wr_mask_i = '0;
    logic [95:0] addr_i = '0;
    logic [47:0] wdata_i = '0;
    logic [2:0]  ack_o;
    logic [15:0] rdata_o;
    logic        busy_o, ram_sel_o, ram_wr_en_o;
    logic [3:0]  ram_wr_mask_o;
    logic [31:0] ram_address_o;
    logic [15:0] ram_data_o, ram_data_i;
    logic [15:0] mem [256];
    int n_assert = 0;
    int n_fail = 0;
    int cnt [3];
    int nacks;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .req_i         (req_i),
`ifdef RAM_ARB_LOCK_EN
        .lock_i        (lock_i),
`endif
        .wr_en_i       (wr_en_i),
        .wr_mask_i     (wr_mask_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .ack_o         (ack_o),
        .rdata_o       (rdata_o),
        .busy_o        (busy_o),
        .ram_sel_o     (ram_sel_o),
        .ram_wr_en_o   (ram_wr_en_o),
        .ram_wr_mask_o (ram_wr_mask_o),
        .ram_address_o (ram_address_o),
        .ram_data_o    (ram_data_o),
        .ram_data_i    (ram_data_i)
    );

    // Synchronous RAM: registered read, per-nibble write mask.
    always @(posedge clk) begin
        if (ram_sel_o) begin
            if (ram_wr_en_o)
                for (int n = 0; n < 4; n++)
                    if (ram_wr_mask_o[n]) mem[ram_address_o[7:0]][n*4 +: 4] <= ram_data_o[n*4 +: 4];
            ram_data_i <= mem[ram_address_o[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction by requester k starting from IDLE.
    task automatic xact(input int k, input logic wr, input logic [3:0] m, input logic [31:0] a,
                        input logic [15:0] d, input logic [15:0] exp_rd);
        req_i = 3'(1 << k);
        wr_en_i[k] = wr;
        wr_mask_i[k*4 +: 4] = m;
        addr_i[k*32 +: 32] = a;
        wdata_i[k*16 +: 16] = d;
        @(negedge clk);
        chk("issue_sel", 64'(ram_sel_o), 64'd1);
        chk("issue_addr", 64'(ram_address_o), 64'(a));
        chk("issue_wen", 64'(ram_wr_en_o), 64'(wr));
        chk("issue_mask", 64'(ram_wr_mask_o), 64'(m));
        chk("issue_wdata", 64'(ram_data_o), 64'(d));
        chk("issue_noack", 64'(ack_o), 64'd0);
        @(negedge clk);
        chk("ack", 64'(ack_o), 64'(1 << k));
        chk("ack_sel0", 64'(ram_sel_o), 64'd0);
        chk("ack_busy", 64'(busy_o), 64'd1);
        if (!wr) chk("ack_rdata", 64'(rdata_o), 64'(exp_rd));
        req_i = '0;
        @(negedge clk);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_noack", 64'(ack_o), 64'd0);
    endtask

    initial begin
        mem[8'h10] <= 16'hBEEF;
        mem[8'h20] <= 16'h1234;
        @(negedge clk);
        chk("rst_ack", 64'(ack_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_sel", 64'(ram_sel_o), 64'd0);
        chk("rst_rdata", 64'(rdata_o), 64'd0);
        chk("rst_addr", 64'(ram_address_o), 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);

        xact(1, 1'b0, 4'h0, 32'h10, 16'h0000, 16'hBEEF);
        chk("rdata_hold", 64'(rdata_o), 64'hBEEF);
        xact(0, 1'b1, 4'b0101, 32'h20, 16'hABCD, 16'h0000);
        xact(0, 1'b0, 4'h0, 32'h20, 16'h0000, 16'h1B3D);
        xact(1, 1'b1, 4'h0, 32'h10, 16'hFFFF, 16'h0000);
        xact(1, 1'b0, 4'h0, 32'h10, 16'h0000, 16'hBEEF);

        // Reset while requester 2 is in ISSUE.
        req_i = 3'b100;
        wr_en_i = 3'b100;
        wr_mask_i[8 +: 4] = 4'hF;
        addr_i[64 +: 32] = 32'h30;
        wdata_i[32 +: 16] = 16'h5A5A;
        @(negedge clk);
        chk("rst2_issue", 64'(ram_sel_o), 64'd1);
        reset_i = 1'b1;
        #1;
        chk("rst2_sel", 64'(ram_sel_o), 64'd0);
        chk("rst2_wen", 64'(ram_wr_en_o), 64'd0);
        chk("rst2_mask", 64'(ram_wr_mask_o), 64'd0);
        chk("rst2_addr", 64'(ram_address_o), 64'd0);
        chk("rst2_wdata", 64'(ram_data_o), 64'd0);
        chk("rst2_busy", 64'(busy_o), 64'd0);
        chk("rst2_rdata", 64'(rdata_o), 64'd0);
        @(negedge clk);
        chk("rst2_noack", 64'(ack_o), 64'd0);
        req_i = '0;
        wr_en_i = '0;
        reset_i = 1'b0;
        @(negedge clk);

        // Simultaneous 0 and 2 from pointer 0.
        addr_i = '0;
        addr_i[0 +: 32] = 32'h10;
        addr_i[64 +: 32] = 32'h20;
        req_i = 3'b101;
        @(negedge clk);
        chk("sim_busy1", 64'(busy_o), 64'd1);
        chk("sim_addr0", 64'(ram_address_o), 64'h10);
        @(negedge clk);
        chk("sim_ack0", 64'(ack_o), 64'b001);
        chk("sim_rd0", 64'(rdata_o), 64'hBEEF);
        req_i = 3'b100;
        @(negedge clk);
        chk("sim_gap", 64'(ack_o), 64'd0);
        chk("sim_busy2", 64'(busy_o), 64'd1);
        chk("sim_addr2", 64'(ram_address_o), 64'h20);
        @(negedge clk);
        chk("sim_ack2", 64'(ack_o), 64'b100);
        chk("sim_rd2", 64'(rdata_o), 64'h1B3D);
        req_i = '0;
        @(negedge clk);
        chk("sim_idle", 64'(busy_o), 64'd0);

        // Fairness: all three requesting continuously for 30 cycles.
        req_i = 3'b111;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (ack_o[0]) cnt[0]++;
            if (ack_o[1]) cnt[1]++;
            if (ack_o[2]) cnt[2]++;
            chk("fair_ack", 64'(ack_o), (c % 2 == 0) ? 64'(1 << ((c / 2 - 1) % 3)) : 64'd0);
        end
        req_i = '0;
        chk("fair_cnt0", 64'(cnt[0]), 64'd5);
        chk("fair_cnt1", 64'(cnt[1]), 64'd5);
        chk("fair_cnt2", 64'(cnt[2]), 64'd5);
        @(negedge clk);
        chk("fair_idle", 64'(busy_o), 64'd0);

`ifdef RAM_ARB_LOCK_EN
        req_i = 3'b010;
        lock_i = 3'b010;
        @(negedge clk);
        req_i = 3'b011;
        nacks = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack_o != 3'b000 && nacks < 17) begin
                seq[nacks] = ack_o;
                nacks++;
            end
        end
        chk("lock_nacks", 64'(nacks), 64'd17);
        for (int i = 0; i < 16; i++) chk("lock_burst", 64'(seq[i]), 64'b010);
        chk("lock_release", 64'(seq[16]), 64'b001);
        req_i = '0;
        lock_i = '0;
        repeat (3) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
